// File: rtl/lampfpu_div_issue_pkg.sv
// Shared lampFPU definitions for the divider issue block.
// Provides float width, rounding/NaN constants, FSM state enum and request bundle.
package lampfpu_div_issue_pkg;

    localparam int unsigned LAMP_FLOAT_DW = 16;

    localparam logic FPU_RNDMODE_NEAREST = 1'b0;

    localparam logic [LAMP_FLOAT_DW-1:0] LAMP_QNAN_CANON = 16'h7FC0;

    localparam int unsigned LAMP_REQ_W = 2*LAMP_FLOAT_DW+1;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_ISSUE,
        DIV_WAIT,
        DIV_ADV,
        DIV_RESP
    } div_state_e;

    typedef struct packed {
        logic                     rnd;
        logic [LAMP_FLOAT_DW-1:0] op1;
        logic [LAMP_FLOAT_DW-1:0] op2;
    } div_req_t;

endpackage

// File: rtl/lampfpu_div_issue_req_fifo.sv
// lampFPU_req_fifo: request FIFO, DEPTH entries (power of two) of WIDTH bits.
// Ports: clk, rst, push_i/data_i, pop_i/data_o (head), full_o, empty_o.
module lampFPU_req_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lampfpu_div_issue.sv
// Divider issue unit: buffers requests, sequences one divide at a time, returns results in order.
// Ports: request (req_*), response (rsp_*), divider drive (do_div_o, padv_o, rndMode_o, op1_o, op2_o),
// divider return (fpu_*). Optional WAIT watchdog enabled by macro LAMPFPU_DIV_TIMEOUT_EN.
module lampfpu_div_issue
    import lampfpu_div_issue_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [LAMP_FLOAT_DW-1:0] req_op1_i,
    input  logic [LAMP_FLOAT_DW-1:0] req_op2_i,
    input  logic                     req_rnd_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [LAMP_FLOAT_DW-1:0] rsp_result_o,
    output logic                     rsp_timeout_o,
    output logic                     do_div_o,
    output logic                     padv_o,
    output logic                     rndMode_o,
    output logic [LAMP_FLOAT_DW-1:0] op1_o,
    output logic [LAMP_FLOAT_DW-1:0] op2_o,
    input  logic [LAMP_FLOAT_DW-1:0] fpu_result_i,
    input  logic                     fpu_valid_i,
    input  logic                     fpu_ready_i
);

    div_state_e               state_q;
    logic [LAMP_FLOAT_DW-1:0] op1_q;
    logic [LAMP_FLOAT_DW-1:0] op2_q;
    logic                     rnd_q;
    logic [LAMP_FLOAT_DW-1:0] res_q;
    logic                     tout_q;

    div_req_t fifo_in;
    div_req_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;

    assign fifo_in   = '{rnd: req_rnd_i, op1: req_op1_i, op2: req_op2_i};
    assign fifo_push = req_valid_i && req_ready_o;
    assign fifo_pop  = (state_q == DIV_IDLE) && !fifo_empty;

    lampFPU_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LAMP_REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req_ready_o   = !fifo_full;
    // The divider may be busy on entry to ISSUE; the pulse waits for its ready.
    assign do_div_o      = (state_q == DIV_ISSUE) && fpu_ready_i;
    assign padv_o        = (state_q == DIV_ADV);
    assign rsp_valid_o   = (state_q == DIV_RESP);
    assign rsp_result_o  = res_q;
    assign rsp_timeout_o = tout_q;
    assign op1_o         = op1_q;
    assign op2_o         = op2_q;
    assign rndMode_o     = rnd_q;

`ifdef LAMPFPU_DIV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES+1);
    logic [CNT_W-1:0] cnt_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            rnd_q   <= FPU_RNDMODE_NEAREST;
            res_q   <= '0;
            tout_q  <= 1'b0;
`ifdef LAMPFPU_DIV_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (!fifo_empty) begin
                        op1_q   <= fifo_head.op1;
                        op2_q   <= fifo_head.op2;
                        rnd_q   <= fifo_head.rnd;
                        tout_q  <= 1'b0;
                        state_q <= DIV_ISSUE;
                    end
                end
                DIV_ISSUE: begin
                    if (fpu_ready_i) begin
`ifdef LAMPFPU_DIV_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                        state_q <= DIV_WAIT;
                    end
                end
                DIV_WAIT: begin
                    if (fpu_valid_i) begin
                        res_q   <= fpu_result_i;
                        state_q <= DIV_ADV;
                    end
`ifdef LAMPFPU_DIV_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                        res_q   <= LAMP_QNAN_CANON;
                        tout_q  <= 1'b1;
                        state_q <= DIV_ADV;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DIV_ADV: begin
                    state_q <= DIV_RESP;
                end
                DIV_RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lampfpu_div_issue.sv
// Bench for lampfpu_div_issue: behavioural divider plus in-order response scoreboard.
// Timeout scenario is built only when LAMPFPU_DIV_TIMEOUT_EN is defined.
module tb_lampfpu_div_issue;
    import lampfpu_div_issue_pkg::*;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [15:0] req_op1_i = '0;
    logic [15:0] req_op2_i = '0;
    logic        req_rnd_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [15:0] rsp_result_o;
    logic        rsp_timeout_o;
    logic        do_div_o;
    logic        padv_o;
    logic        rndMode_o;
    logic [15:0] op1_o;
    logic [15:0] op2_o;
    logic [15:0] fpu_result_i;
    logic        fpu_valid_i;
    logic        fpu_ready_i;

    always #5 clk = ~clk;

    lampfpu_div_issue #(
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op1_i     (req_op1_i),
        .req_op2_i     (req_op2_i),
        .req_rnd_i     (req_rnd_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_result_o  (rsp_result_o),
        .rsp_timeout_o (rsp_timeout_o),
        .do_div_o      (do_div_o),
        .padv_o        (padv_o),
        .rndMode_o     (rndMode_o),
        .op1_o         (op1_o),
        .op2_o         (op2_o),
        .fpu_result_i  (fpu_result_i),
        .fpu_valid_i   (fpu_valid_i),
        .fpu_ready_i   (fpu_ready_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic real bf2r(input logic [15:0] a);
        logic [10:0] e;
        if (a[14:0] == '0) return 0.0;
        e = {3'b0, a[14:7]} + 11'd896;
        return $bitstoreal({a[15], e, a[6:0], 45'h0});
    endfunction

    function automatic logic [15:0] bdiv(input logic [15:0] a, input logic [15:0] b);
        real         q;
        logic [63:0] d;
        logic [10:0] e;
        if (b[14:0] == '0) return {a[15] ^ b[15], 8'hFF, 7'h0};
        q = bf2r(a) / bf2r(b);
        if (q == 0.0) return 16'h0;
        d = $realtobits(q);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:45]};
    endfunction

    // Divider model: samples operands at do_div, computes from live operands at completion.
    int          lat = 3;
    bit          hang = 1'b0;
    logic        busy;
    int          cnt;
    logic [15:0] h1, h2;
    logic        hr;
    int          op_moved = 0;

    assign fpu_ready_i = !busy;

    always @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            fpu_valid_i  <= 1'b0;
            fpu_result_i <= '0;
            cnt          <= 0;
        end else begin
            if (busy && (op1_o !== h1 || op2_o !== h2 || rndMode_o !== hr))
                op_moved <= op_moved + 1;
            if (padv_o) begin
                busy        <= 1'b0;
                fpu_valid_i <= 1'b0;
            end else if (do_div_o) begin
                busy <= 1'b1;
                cnt  <= lat;
                h1   <= op1_o;
                h2   <= op2_o;
                hr   <= rndMode_o;
            end else if (busy && !fpu_valid_i && !hang) begin
                if (cnt == 0) begin
                    fpu_valid_i  <= 1'b1;
                    fpu_result_i <= bdiv(op1_o, op2_o);
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    logic [16:0] sb[$];
    int cyc = 0, n_div = 0, n_padv = 0, both = 0, div_cyc = 0, padv_cyc = 0;
    bit full_seen = 1'b0;

    always @(negedge clk) begin
        logic [16:0] e;
        cyc++;
        if (do_div_o) begin n_div++; div_cyc = cyc; end
        if (padv_o) begin n_padv++; padv_cyc = cyc; end
        if (do_div_o && padv_o) both++;
        if (req_valid_i && !req_ready_o) full_seen = 1'b1;
        if (!rst && rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_result", 32'(rsp_result_o), 32'(e[15:0]));
                check("rsp_timeout", 32'(rsp_timeout_o), 32'(e[16]));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic r,
                        input logic [15:0] exp, input logic tmo);
        req_op1_i   = a;
        req_op2_i   = b;
        req_rnd_i   = r;
        req_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready_o) break;
        end
        if (req_ready_o) sb.push_back({tmo, exp});
        else check("req_accept_wait", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid_o) break;
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_do_div"}, 32'(do_div_o), 32'd0);
        check({tag, "_padv"}, 32'(padv_o), 32'd0);
        check({tag, "_timeout"}, 32'(rsp_timeout_o), 32'd0);
        check({tag, "_op1"}, 32'(op1_o), 32'd0);
        check({tag, "_op2"}, 32'(op2_o), 32'd0);
        check({tag, "_result"}, 32'(rsp_result_o), 32'd0);
        check({tag, "_rnd"}, 32'(rndMode_o), 32'(FPU_RNDMODE_NEAREST));
        check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    int d0, p0, bad;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks("reset");

        // single request, response held until accepted
        @(posedge clk);
        #1;
        d0 = n_div;
        p0 = n_padv;
        send(16'h40C0, 16'h4000, 1'b1, 16'h4040, 1'b0);
        wait_rsp();
        check("t1_valid", 32'(rsp_valid_o), 32'd1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_result_o !== 16'h4040) bad++;
        end
        check("t1_hold", 32'(bad), 32'd0);
        check("t1_div_pulses", 32'(n_div - d0), 32'd1);
        check("t1_padv_pulses", 32'(n_padv - p0), 32'd1);
        @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        drain();

        // back-to-back, in-order responses
        full_seen = 1'b0;
        send(16'h3F80, 16'h4000, 1'b0, 16'h3F00, 1'b0);
        send(16'h4120, 16'h40A0, 1'b0, 16'h4000, 1'b0);
        send(16'hC080, 16'h4000, 1'b0, 16'hC000, 1'b0);
        send(16'h40E0, 16'h4000, 1'b0, 16'h4060, 1'b0);
        drain();
        check("t2_full_stall", 32'(full_seen), 32'd1);

        // consumer stalled: result stable, FIFO fills
        rsp_ready_i = 1'b0;
        d0 = n_div;
        send(16'h4000, 16'h4000, 1'b0, 16'h3F80, 1'b0);
        send(16'h4080, 16'h4000, 1'b0, 16'h4000, 1'b0);
        send(16'h3F80, 16'h3F80, 1'b0, 16'h3F80, 1'b0);
        wait_rsp();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_result_o !== 16'h3F80) bad++;
        end
        check("t3_stable", 32'(bad), 32'd0);
        check("t3_one_div", 32'(n_div - d0), 32'd1);
        check("t3_full", 32'(req_ready_o), 32'd0);
        @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        drain();

        // divide by zero
        send(16'h3F80, 16'h0000, 1'b1, 16'h7F80, 1'b0);
        drain();
        check("op_hold", 32'(op_moved), 32'd0);

`ifdef LAMPFPU_DIV_TIMEOUT_EN
        hang = 1'b1;
        p0 = n_padv;
        send(16'h3F80, 16'h4000, 1'b0, LAMP_QNAN_CANON, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_padv != p0) break;
        end
        check("tmo_padv", 32'(n_padv - p0), 32'd1);
        check("tmo_wait_len", 32'(padv_cyc - div_cyc), 32'(TMO + 1));
        drain();
        hang = 1'b0;
`endif

        // reset while waiting on the divider
        lat = 10;
        d0 = n_div;
        p0 = n_padv;
        send(16'h40C0, 16'h4000, 1'b1, 16'h4040, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (n_div != d0) break;
        end
        check("t6_issued", 32'(n_div - d0), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        reset_checks("midrst");
        check("midrst_no_padv", 32'(n_padv - p0), 32'd0);
        lat = 3;
        send(16'h40E0, 16'h4000, 1'b0, 16'h4060, 1'b0);
        drain();

        check("div_padv_overlap", 32'(both), 32'd0);
        check("op_hold_final", 32'(op_moved), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lampfpu_div_issue.md
LAMPFPU_DIV_ISSUE -- requirements
Module: lampFPU_div_issue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of buffered requests (power of two, at least 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum WAIT cycles before abort (used only with REQ-027).
REQ-003 SHALL have: clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have: req_valid_i  in  1; req_ready_o  out  1; req_op1_i, req_op2_i  in  LAMP_FLOAT_DW; req_rnd_i  in  1. Together these form the request port.
REQ-006 SHALL have: rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_result_o  out  LAMP_FLOAT_DW; rsp_timeout_o  out  1. Together these form the response port.
REQ-007 SHALL have: do_div_o  out  1; padv_o  out  1; rndMode_o  out  1; op1_o, op2_o  out  LAMP_FLOAT_DW. These drive the divider.
REQ-008 SHALL have: fpu_result_i  in  LAMP_FLOAT_DW; fpu_valid_i  in  1; fpu_ready_i  in  1. These are driven by the divider.

Function
REQ-009 SHALL accept a request into the FIFO when req_valid_i and req_ready_o are both high in the same cycle.
REQ-010 SHALL drive req_ready_o high exactly when the FIFO is not full; it SHALL NOT depend combinationally on req_valid_i.
REQ-011 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> ADV -> RESP -> IDLE.
REQ-012 IDLE: if the FIFO is non-empty, SHALL load the head entry into the operand holding registers, pop the FIFO, and go to ISSUE.
REQ-013 ISSUE: SHALL drive do_div_o high for exactly one cycle, in the first cycle fpu_ready_i is high, then go to WAIT.
REQ-014 SHALL hold op1_o, op2_o and rndMode_o constant from IDLE exit until ADV exit, because the divider samples operands continuously during its computation.
REQ-015 WAIT: on fpu_valid_i high, SHALL capture fpu_result_i into rsp_result_o and go to ADV.
REQ-016 ADV: SHALL drive padv_o high for exactly one cycle, then go to RESP.
REQ-017 RESP: SHALL hold rsp_valid_o high, with rsp_result_o stable, until rsp_ready_i is high; then go to IDLE.
REQ-018 SHALL allow a FIFO push in the same cycle as a FIFO pop when full; occupancy is then unchanged.
REQ-019 SHALL keep do_div_o and padv_o low outside ISSUE and ADV respectively; they SHALL never be high in the same cycle.
REQ-020 Minimum latency from request acceptance to rsp_valid_o SHALL be divider latency + 4 cycles.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate count deciding full and empty.
REQ-022 SHALL return responses in request order.

Reset
REQ-023 On rst, the FSM SHALL go to IDLE and the FIFO SHALL empty.
REQ-024 On rst, do_div_o, padv_o, rsp_valid_o and rsp_timeout_o SHALL be 0, and req_ready_o SHALL be 1 from the cycle after reset deasserts.
REQ-025 On rst, op1_o, op2_o, rsp_result_o and the timeout counter SHALL be 0, and rndMode_o SHALL be FPU_RNDMODE_NEAREST.
REQ-026 Reset mid-operation SHALL abandon the in-flight request without asserting padv_o; the divider shares rst.

Configuration
REQ-027 With LAMPFPU_DIV_TIMEOUT_EN defined, SHALL count WAIT cycles. On reaching TIMEOUT_CYCLES it SHALL:
- set rsp_result_o to LAMP_QNAN_CANON;
- set rsp_timeout_o to 1;
- go to ADV.
The counter SHALL clear on entry to WAIT.
REQ-028 Without LAMPFPU_DIV_TIMEOUT_EN, WAIT SHALL last indefinitely, no counter logic SHALL exist, and rsp_timeout_o SHALL be tied 0.

Structure
REQ-029 LAMP_FLOAT_DW, FPU_RNDMODE_NEAREST, LAMP_QNAN_CANON and the FSM state enum typedef SHALL reside in the shared lampFPU package header.
REQ-030 The request FIFO SHALL be a sub-module, lampFPU_req_fifo, parameterised by depth and width (2*LAMP_FLOAT_DW+1).

Verification (LAMP_FLOAT_DW=16, bfloat16 encoding)
REQ-031 Reset, then a single request op1=0x40C0, op2=0x4000 -> one do_div_o pulse, one padv_o pulse, rsp_result_o=0x4040, rsp_valid_o held until rsp_ready_i.
REQ-032 Three back-to-back requests (0x3F80/0x4000, 0x4120/0x40A0, 0xC080/0x4000) with rsp_ready_i=1 -> responses 0x3F00, 0x4000, 0xC000 in order; req_ready_o low while the FIFO is full.
REQ-033 rsp_ready_i held low for 20 cycles -> rsp_result_o stable throughout, no second do_div_o pulse, FIFO fills and req_ready_o=0.
REQ-034 Request 0x3F80/0x0000 -> rsp_result_o=0x7F80 (+inf); op1_o and op2_o unchanged every cycle between ISSUE and ADV.
REQ-035 With LAMPFPU_DIV_TIMEOUT_EN and TIMEOUT_CYCLES=8, fpu_valid_i forced low -> after 8 WAIT cycles rsp_result_o=LAMP_QNAN_CANON, rsp_timeout_o=1, one padv_o pulse.
REQ-036 rst asserted during WAIT -> next cycle all outputs at reset values, FIFO empty; a following request completes normally.
